// File: rtl/ysyx_24100006_idu_hs_if.sv
// IFU->IDU issue channel, IDU->EXU bundle channel and WBU write-back port of the
// ysyx_24100006 decode stage. master = surrounding core, slave = decode stage.
interface ysyx_24100006_idu_hs_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;
  logic            flush;
  logic            wb_wen;
  logic [4:0]      wb_waddr;
  logic [XLEN-1:0] wb_wdata;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_inst;
  logic [XLEN-1:0] out_rs1_data;
  logic [XLEN-1:0] out_rs2_data;
  logic [XLEN-1:0] out_imm;
  logic [4:0]      out_rd;
  logic            out_gpr_wen;
  logic            out_illegal;

  modport master (
    output in_valid, in_inst, in_pc, flush, wb_wen, wb_waddr, wb_wdata, out_ready,
    input  in_ready, out_valid, out_pc, out_inst, out_rs1_data, out_rs2_data,
           out_imm, out_rd, out_gpr_wen, out_illegal
  );

  modport slave (
    input  in_valid, in_inst, in_pc, flush, wb_wen, wb_waddr, wb_wdata, out_ready,
    output in_ready, out_valid, out_pc, out_inst, out_rs1_data, out_rs2_data,
           out_imm, out_rd, out_gpr_wen, out_illegal
  );
endinterface

// File: rtl/ysyx_24100006_idu_hs.sv
// Handshaked decode stage: GPR file, busy-bit scoreboard, registered EXU bundle.
// Define YSYX_24100006_BYPASS_EN to forward same-cycle write-back data into issue.
module ysyx_24100006_idu_hs #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NR_REG = 32
) (
  input logic                   clk,
  input logic                   reset,
  ysyx_24100006_idu_hs_if.slave bus
);
  localparam int unsigned RW = $clog2(NR_REG);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [4:0]      rd, rs1, rs2;
  logic [RW-1:0]   rd_i, rs1_i, rs2_i, wb_i;
  logic            writes_rd, reads_rs1, reads_rs2;
  logic            gpr_wen, illegal;
  logic [XLEN-1:0] imm;
  logic            wb_ok, wb_clr;
  logic            fwd_rs1, fwd_rs2, wb_hit_rd;
  logic            hazard, in_ready, fire;
  logic [XLEN-1:0] rs1_data, rs2_data;

  logic [XLEN-1:0] gpr_q [NR_REG];
  logic [XLEN-1:0] gpr_d [NR_REG];
  logic [NR_REG-1:0] busy_q, busy_d;

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;
  logic [31:0]     out_inst_q, out_inst_d;
  logic [XLEN-1:0] out_rs1_data_q, out_rs1_data_d;
  logic [XLEN-1:0] out_rs2_data_q, out_rs2_data_d;
  logic [XLEN-1:0] out_imm_q, out_imm_d;
  logic [4:0]      out_rd_q, out_rd_d;
  logic            out_gpr_wen_q, out_gpr_wen_d;
  logic            out_illegal_q, out_illegal_d;

  assign opcode = bus.in_inst[6:0];
  assign funct3 = bus.in_inst[14:12];
  assign rd     = bus.in_inst[11:7];
  assign rs1    = bus.in_inst[19:15];
  assign rs2    = bus.in_inst[24:20];
  assign rd_i   = rd[RW-1:0];
  assign rs1_i  = rs1[RW-1:0];
  assign rs2_i  = rs2[RW-1:0];
  assign wb_i   = bus.wb_waddr[RW-1:0];

  // Register-use classes and immediate format by opcode.
  always_comb begin
    writes_rd = 1'b0;
    reads_rs1 = 1'b0;
    reads_rs2 = 1'b0;
    imm       = '0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        writes_rd = 1'b1;
        imm       = XLEN'($signed({bus.in_inst[31:12], 12'b0}));
      end
      OPC_JAL: begin
        writes_rd = 1'b1;
        imm       = XLEN'($signed({bus.in_inst[31], bus.in_inst[19:12], bus.in_inst[20],
                                   bus.in_inst[30:21], 1'b0}));
      end
      OPC_JALR, OPC_LOAD, OPC_OP_IMM: begin
        writes_rd = 1'b1;
        reads_rs1 = 1'b1;
        imm       = XLEN'($signed(bus.in_inst[31:20]));
      end
      OPC_BRANCH: begin
        reads_rs1 = 1'b1;
        reads_rs2 = 1'b1;
        imm       = XLEN'($signed({bus.in_inst[31], bus.in_inst[7], bus.in_inst[30:25],
                                   bus.in_inst[11:8], 1'b0}));
      end
      OPC_STORE: begin
        reads_rs1 = 1'b1;
        reads_rs2 = 1'b1;
        imm       = XLEN'($signed({bus.in_inst[31:25], bus.in_inst[11:7]}));
      end
      OPC_OP: begin
        writes_rd = 1'b1;
        reads_rs1 = 1'b1;
        reads_rs2 = 1'b1;
      end
      OPC_SYSTEM: begin
        writes_rd = (funct3 != 3'd0);
        reads_rs1 = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd3);
        imm       = XLEN'($signed(bus.in_inst[31:20]));
      end
      default: ;
    endcase
  end

  assign gpr_wen = writes_rd & (rd != 5'd0);
  assign illegal = (reads_rs1 & (32'(rs1) >= NR_REG))
                 | (reads_rs2 & (32'(rs2) >= NR_REG))
                 | (gpr_wen   & (32'(rd)  >= NR_REG));

  // Out-of-range write-backs never touch the array; busy release uses the low index bits.
  assign wb_ok  = bus.wb_wen & (bus.wb_waddr != 5'd0) & (32'(bus.wb_waddr) < NR_REG);
  assign wb_clr = bus.wb_wen & (bus.wb_waddr != 5'd0);

`ifdef YSYX_24100006_BYPASS_EN
  assign fwd_rs1   = wb_ok & (bus.wb_waddr == rs1);
  assign fwd_rs2   = wb_ok & (bus.wb_waddr == rs2);
  assign wb_hit_rd = wb_clr & (bus.wb_waddr == rd);
`else
  assign fwd_rs1   = 1'b0;
  assign fwd_rs2   = 1'b0;
  assign wb_hit_rd = 1'b0;
`endif

  assign rs1_data = fwd_rs1 ? bus.wb_wdata : gpr_q[rs1_i];
  assign rs2_data = fwd_rs2 ? bus.wb_wdata : gpr_q[rs2_i];

  assign hazard = (reads_rs1 & busy_q[rs1_i] & ~fwd_rs1)
                | (reads_rs2 & busy_q[rs2_i] & ~fwd_rs2)
                | (gpr_wen   & busy_q[rd_i]  & ~wb_hit_rd);

  assign in_ready = ~bus.flush & ~hazard & (~out_valid_q | bus.out_ready);
  assign fire     = bus.in_valid & in_ready;

  // GPR write and scoreboard update; a same-cycle issue re-marks its rd busy.
  always_comb begin
    gpr_d = gpr_q;
    if (wb_ok) gpr_d[wb_i] = bus.wb_wdata;
    busy_d = busy_q;
    if (wb_clr) busy_d[wb_i] = 1'b0;
    if (fire && gpr_wen) busy_d[rd_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    out_valid_d    = out_valid_q;
    out_pc_d       = out_pc_q;
    out_inst_d     = out_inst_q;
    out_rs1_data_d = out_rs1_data_q;
    out_rs2_data_d = out_rs2_data_q;
    out_imm_d      = out_imm_q;
    out_rd_d       = out_rd_q;
    out_gpr_wen_d  = out_gpr_wen_q;
    out_illegal_d  = out_illegal_q;
    if (fire) begin
      out_valid_d    = 1'b1;
      out_pc_d       = bus.in_pc;
      out_inst_d     = bus.in_inst;
      out_rs1_data_d = rs1_data;
      out_rs2_data_d = rs2_data;
      out_imm_d      = imm;
      out_rd_d       = rd;
      out_gpr_wen_d  = gpr_wen;
      out_illegal_d  = illegal;
    end else if (bus.flush || bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gpr_q          <= '{default: '0};
      busy_q         <= '0;
      out_valid_q    <= 1'b0;
      out_pc_q       <= '0;
      out_inst_q     <= '0;
      out_rs1_data_q <= '0;
      out_rs2_data_q <= '0;
      out_imm_q      <= '0;
      out_rd_q       <= '0;
      out_gpr_wen_q  <= 1'b0;
      out_illegal_q  <= 1'b0;
    end else begin
      gpr_q          <= gpr_d;
      busy_q         <= busy_d;
      out_valid_q    <= out_valid_d;
      out_pc_q       <= out_pc_d;
      out_inst_q     <= out_inst_d;
      out_rs1_data_q <= out_rs1_data_d;
      out_rs2_data_q <= out_rs2_data_d;
      out_imm_q      <= out_imm_d;
      out_rd_q       <= out_rd_d;
      out_gpr_wen_q  <= out_gpr_wen_d;
      out_illegal_q  <= out_illegal_d;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_pc       = out_pc_q;
  assign bus.out_inst     = out_inst_q;
  assign bus.out_rs1_data = out_rs1_data_q;
  assign bus.out_rs2_data = out_rs2_data_q;
  assign bus.out_imm      = out_imm_q;
  assign bus.out_rd       = out_rd_q;
  assign bus.out_gpr_wen  = out_gpr_wen_q;
  assign bus.out_illegal  = out_illegal_q;

endmodule

// File: doc/ysyx_24100006_idu_hs.md
# ysyx_24100006_idu_hs

Parametrised, handshaked instruction-decode stage for the ysyx_24100006 core. It accepts instructions from the IFU over a valid/ready channel and reads the general-purpose register file. It tracks outstanding register writes with a scoreboard and stalls read-after-write and write-after-write hazards. It hands a registered decode bundle to the EXU over a second valid/ready channel, so the core can run multi-cycle and pipelined instead of lock-step.

## Interface
Parameters:
- XLEN, 32, data width of registers, PC and immediates.
- NR_REG, 32, number of GPRs: 32 (RV32I) or 16 (RV32E); index width RW = $clog2(NR_REG).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  IFU offers an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_inst  in  32  instruction word.
- in_pc  in  XLEN  instruction PC.
- flush  in  1  kill the held output and block acceptance this cycle.
- wb_wen  in  1  WBU writes a GPR.
- wb_waddr  in  5  WBU destination register.
- wb_wdata  in  XLEN  WBU write data.
- out_valid  out  1  decode bundle valid.
- out_ready  in  1  EXU accepts the bundle.
- out_pc  out  XLEN  registered PC.
- out_inst  out  32  registered instruction, for downstream control decode.
- out_rs1_data  out  XLEN  rs1 operand.
- out_rs2_data  out  XLEN  rs2 operand.
- out_imm  out  XLEN  sign-extended immediate.
- out_rd  out  5  destination index.
- out_gpr_wen  out  1  instruction writes rd, and rd != 0.
- out_illegal  out  1  an index used by the instruction is >= NR_REG.

## Operation
- Use classes, by opcode:
  - Writes rd: LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, and SYSTEM with funct3 != 0.
  - Reads rs1: JALR, BRANCH, LOAD, STORE, OP-IMM, OP, and SYSTEM with funct3 in {1,2,3}.
  - Reads rs2: BRANCH, STORE, OP.
- Immediate formats:
  - I-type: LOAD, OP-IMM, JALR, SYSTEM.
  - S-type: STORE.
  - B-type: BRANCH.
  - U-type: LUI, AUIPC.
  - J-type: JAL.
  - All other opcodes: 0.
  - Sign bit is always inst[31].
- GPR array:
  - Holds NR_REG x XLEN registers; x0 reads 0 and ignores writes.
  - A write with wb_waddr >= NR_REG is dropped.
  - Read indices use the low RW bits.
- Scoreboard:
  - One busy bit per register; x0 is never busy.
  - hazard = (reads rs1 and busy[rs1]) | (reads rs2 and busy[rs2]) | (writes rd and busy[rd]).
- in_ready = !flush & !hazard & (!out_valid | out_ready).
- fire = in_valid & in_ready. On fire:
  - Load the output bundle with the GPR read data and the decoded fields.
  - Set out_valid.
  - Set busy[rd] if out_gpr_wen.
- If out_valid & out_ready and no fire, clear out_valid.
- On wb_wen with wb_waddr != 0, clear busy[wb_waddr]. If fire sets the same rd in the same cycle, set wins.
- A wb_wen to a non-busy register performs the write and leaves busy unchanged.
- Flush:
  - Clears out_valid next cycle.
  - Busy bits of already-issued instructions are untouched; they still write back.
  - The busy bit set by the flushed instruction stays set; the EXU must still retire it with wb_wen. Flush only discards the unissued bundle when the EXU has not yet accepted it and the EXU writes rd as a null write-back.
- out_illegal is registered with the bundle. The instruction still issues; the EXU raises the exception.

## Timing
- Reset values:
  - out_valid = 0, in_ready follows its equation.
  - All busy bits = 0; all GPRs = 0.
  - out_pc, out_inst, out_rs1_data, out_rs2_data, out_imm, out_rd = 0.
  - out_gpr_wen = 0, out_illegal = 0.
- Reset asserted mid-operation discards any held bundle and all busy state at the next edge.
- Latency: one cycle from fire to out_valid.
- Back-to-back throughput: one instruction per cycle when there is no hazard and out_ready is high.
- Output bundle is stable while out_valid & !out_ready. The IFU must hold in_inst and in_pc while in_valid & !in_ready.
- Without bypass, a GPR write becomes visible to reads one cycle after wb_wen.

## Configuration
- YSYX_24100006_BYPASS_EN defined:
  - A WB write in the same cycle to a read rs1 or rs2 forwards wb_wdata to the operand.
  - That register's busy bit is ignored in the hazard term.
  - A busy rd being written back that cycle does not stall.
  - Result: a dependent instruction issues in the write-back cycle.
- YSYX_24100006_BYPASS_EN undefined:
  - No forwarding; hazard uses the registered busy bits.
  - A dependent instruction issues the cycle after write-back.

## Test plan
- Reset then `addi x1,x0,5` with out_ready=1: out_valid=1 one cycle after fire, out_imm=5, out_rd=1, out_gpr_wen=1, busy[1]=1.
- `addi x1,x0,5` then `add x2,x1,x1` with wb x1=5 issued 3 cycles later:
  - in_ready=0 until write-back.
  - With BYPASS_EN, the add fires in the write-back cycle with rs1/rs2_data=5.
  - Without BYPASS_EN, it fires one cycle later.
- out_ready held 0 for 4 cycles with two independent instructions offered: the first bundle is stable, the second waits, in_ready=0; both issue in order once out_ready=1.
- Flush asserted while a bundle is held: out_valid=0 next cycle, in_ready=0 during the flush cycle, GPRs unchanged.
- NR_REG=16 with `addi x17,x0,1`: out_illegal=1. A wb to x20 leaves all registers unchanged; a write to x0 reads back 0.
- Same-cycle fire setting busy[3] and wb clearing busy[3]: busy[3]=1 afterwards.
